axis_fcs_append: RTL
====================

// Module: axis_fcs_append
// PURPOSE
// - Byte-wide AXI-Stream Ethernet TX stage. Sits downstream of the frame builder and upstream of the MAC/PHY serializer.
// - Passes each frame through unchanged, then appends the 4-byte IEEE 802.3 FCS (CRC-32).
// - Optionally zero-pads short frames to the minimum length before the FCS.
// PARAMETERS
// - USER_WIDTH       1   tuser width in bits; passed through.
// - MIN_FRAME_BYTES  60  minimum payload bytes before the FCS (used only when the pad feature is compiled in).
// PORTS
// - clock     in   1           single clock; all logic on posedge.
// - reset     in   1           synchronous, active-high.
// - s_tdata   in   8           input frame byte.
// - s_tvalid  in   1           input valid.
// - s_tready  out  1           input ready.
// - s_tlast   in   1           last payload byte of the frame.
// - s_tuser   in   USER_WIDTH  sideband.
// - m_tdata   out  8           output byte.
// - m_tvalid  out  1           output valid.
// - m_tready  in   1           output ready.
// - m_tlast   out  1           asserted on FCS byte 3 only.
// - m_tuser   out  USER_WIDTH  sideband.
// BEHAVIOUR
// - Reset:
//   - state=PASS, crc=32'hFFFF_FFFF, byte_cnt=0, fcs_idx=0.
//   - While reset is high, s_tready=0 and m_tvalid=0. m_tlast=0, m_tdata=0, m_tuser=0.
// - Beat: transfer occurs when valid&&ready on that side. An input tkeep does not exist; every beat is one byte.
// - PASS:
//   - Combinational pass-through, 0 latency: m_tvalid=s_tvalid, s_tready=m_tready, m_tdata=s_tdata, m_tuser=s_tuser, m_tlast=0.
//   - On each input transfer: crc<=crc32_d8(crc,s_tdata); byte_cnt saturating +1; tuser latched.
//   - On a transfer with s_tlast=1: goto PAD if the pad feature is on and byte_cnt+1<MIN_FRAME_BYTES, else goto FCS.
// - PAD:
//   - s_tready=0, m_tvalid=1, m_tdata=8'h00, m_tuser=latched, m_tlast=0.
//   - Each m transfer updates crc with 8'h00 and byte_cnt+1.
//   - Goto FCS on the transfer where byte_cnt+1==MIN_FRAME_BYTES.
// - FCS:
//   - s_tready=0, m_tvalid=1, m_tdata=~crc[8*fcs_idx+:8], so the inverted reflected CRC goes out LSB byte first.
//   - m_tuser=latched; m_tlast=(fcs_idx==3).
//   - crc is held constant in FCS.
//   - On the transfer with fcs_idx==3: crc<=FFFF_FFFF, byte_cnt<=0, fcs_idx<=0, goto PASS. The next frame may start on the following cycle.
// - CRC: reflected poly 32'hEDB8_8320, init all-ones, processed LSB-first, final XOR all-ones.
// - byte_cnt width is $clog2(MIN_FRAME_BYTES+1) and saturates at MIN_FRAME_BYTES, so frames of any length are legal.
// - Outputs are stable while m_tvalid&&!m_tready in PAD/FCS. In PASS they are stable only if upstream holds its own outputs stable.
// - Frames already >= MIN bytes go PASS->FCS directly.
// - A 1-byte frame is legal.
// - Reset mid-frame: abandon the frame, return to reset state next cycle. The partial frame gets no FCS.
// - s_tvalid with no tlast indefinitely: remain in PASS; the CRC keeps accumulating.
// CONFIGURATION
// - Macro AXIS_FCS_APPEND_PAD_EN:
//   - Defined: PAD state exists; short frames are zero-padded to MIN_FRAME_BYTES before the FCS.
//   - Undefined: PAD state and byte_cnt are removed; PASS goes directly to FCS; MIN_FRAME_BYTES is ignored.
// STRUCTURE
// - Shared package eth_pkg holds:
//   - CRC32_POLY_REFLECTED=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, ETH_MIN_FRAME_BYTES=60.
//   - typedef logic [31:0] crc32_t.
//   - typedef enum logic [1:0] {FCS_PASS, FCS_PAD, FCS_EMIT} fcs_state_t.
// - Sub-module eth_crc32_d8: purely combinational (crc_in, data) -> crc_out, a one-byte update. It is reusable by the RX FCS checker.
// TESTING
// - Without pad, 9-byte frame "123456789" (31..39h), m_tready=1:
//   -> bytes 31..39h, then 26h,39h,F4h,CBh; m_tlast only on CBh (CRC 0xCBF43926).
// - With pad, same frame:
//   -> 9 data bytes, 51 bytes 00h, then a 4-byte FCS matching the software CRC-32 of those 60 bytes.
//   -> 64 beats total; tuser is constant throughout.
// - 60-byte frame with pad enabled:
//   -> no pad bytes; FCS follows byte 60 directly.
//   - 1-byte frame 00h -> 59 pad bytes then the FCS.
// - Back-to-back frames with s_tvalid held high:
//   -> s_tready=0 for exactly the 4 FCS cycles (plus pad cycles).
//   -> The second frame's CRC is independent of the first, and its FCS matches the model.
// - Random m_tready (30% low):
//   -> m_tdata, m_tlast and m_tuser are stable during stalls in PAD/FCS.
//   -> The byte stream equals the model with no drops or duplicates.
// - Assert reset for 1 cycle mid-payload (byte 5):
//   -> m_tvalid=0 during reset; no FCS is emitted for the partial frame.
//   -> The next full frame's FCS is correct, starting from init.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, FCS stage state encoding.
package eth_pkg;

    typedef logic [31:0] crc32_t;

    localparam crc32_t      CRC32_POLY_REFLECTED = 32'hEDB8_8320;
    localparam crc32_t      CRC32_INIT           = 32'hFFFF_FFFF;
    localparam int unsigned ETH_MIN_FRAME_BYTES  = 60;

    typedef enum logic [1:0] {
        FCS_PASS,
        FCS_PAD,
        FCS_EMIT
    } fcs_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte update of the reflected IEEE 802.3 CRC-32 (LSB-first), purely combinational.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  crc32_t      crc_in,
    input  logic [7:0]  data,
    output crc32_t      crc_out
);

    crc32_t crc_work;

    // Fold the byte into the low bits, then shift out eight bits through the polynomial.
    always_comb begin
        crc_work = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_work[0]) begin
                crc_work = (crc_work >> 1) ^ CRC32_POLY_REFLECTED;
            end else begin
                crc_work = crc_work >> 1;
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/axis_fcs_append.sv
// Byte-wide AXI-Stream TX stage: passes the frame through and appends the CRC-32 FCS.
// Optional zero-padding of short frames is compiled in with AXIS_FCS_APPEND_PAD_EN.
module axis_fcs_append
    import eth_pkg::*;
#(
    parameter int unsigned USER_WIDTH      = 1,
    parameter int unsigned MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [USER_WIDTH-1:0] s_tuser,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser
);

    fcs_state_t            state_q, state_d;
    crc32_t                crc_q, crc_d, crc_upd;
    logic [1:0]            fcs_idx_q, fcs_idx_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic [7:0]            crc_data;

`ifdef AXIS_FCS_APPEND_PAD_EN
    localparam int unsigned         CNT_W        = $clog2(MIN_FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX      = CNT_W'(MIN_FRAME_BYTES);
    localparam logic [CNT_W-1:0]    CNT_LAST_PAD = CNT_W'(MIN_FRAME_BYTES - 1);

    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
`else
    logic unused_min_frame;
    assign unused_min_frame = (MIN_FRAME_BYTES != 0);
`endif

    // Payload bytes feed the CRC in PASS; pad bytes are zero.
    assign crc_data = (state_q == FCS_PASS) ? s_tdata : 8'h00;

    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_data),
        .crc_out (crc_upd)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FCS_PASS;
            crc_q      <= CRC32_INIT;
            fcs_idx_q  <= 2'd0;
            user_q     <= '0;
`ifdef AXIS_FCS_APPEND_PAD_EN
            byte_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            fcs_idx_q  <= fcs_idx_d;
            user_q     <= user_d;
`ifdef AXIS_FCS_APPEND_PAD_EN
            byte_cnt_q <= byte_cnt_d;
`endif
        end
    end

    // Next-state and stream outputs; everything is quiet while reset is high.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        fcs_idx_d  = fcs_idx_q;
        user_d     = user_q;
`ifdef AXIS_FCS_APPEND_PAD_EN
        byte_cnt_d = byte_cnt_q;
`endif
        s_tready   = 1'b0;
        m_tvalid   = 1'b0;
        m_tdata    = 8'h00;
        m_tlast    = 1'b0;
        m_tuser    = '0;

        if (!reset) begin
            case (state_q)
                FCS_PASS: begin
                    s_tready = m_tready;
                    m_tvalid = s_tvalid;
                    m_tdata  = s_tdata;
                    m_tuser  = s_tuser;
                    if (s_tvalid && m_tready) begin
                        crc_d  = crc_upd;
                        user_d = s_tuser;
`ifdef AXIS_FCS_APPEND_PAD_EN
                        if (byte_cnt_q != CNT_MAX) begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                        if (s_tlast) begin
                            state_d = (byte_cnt_q < CNT_LAST_PAD) ? FCS_PAD : FCS_EMIT;
                        end
`else
                        if (s_tlast) begin
                            state_d = FCS_EMIT;
                        end
`endif
                    end
                end
`ifdef AXIS_FCS_APPEND_PAD_EN
                FCS_PAD: begin
                    m_tvalid = 1'b1;
                    m_tuser  = user_q;
                    if (m_tready) begin
                        crc_d      = crc_upd;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        if (byte_cnt_q == CNT_LAST_PAD) begin
                            state_d = FCS_EMIT;
                        end
                    end
                end
`endif
                FCS_EMIT: begin
                    m_tvalid = 1'b1;
                    m_tdata  = ~crc_q[{fcs_idx_q, 3'b000} +: 8];
                    m_tuser  = user_q;
                    m_tlast  = (fcs_idx_q == 2'd3);
                    if (m_tready) begin
                        if (fcs_idx_q == 2'd3) begin
                            state_d    = FCS_PASS;
                            crc_d      = CRC32_INIT;
                            fcs_idx_d  = 2'd0;
`ifdef AXIS_FCS_APPEND_PAD_EN
                            byte_cnt_d = '0;
`endif
                        end else begin
                            fcs_idx_d = fcs_idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = FCS_PASS;
                end
            endcase
        end
    end

endmodule
